sd_sector_responder: RTL and testbench

FPGA-side responder for the sector-buffer interface (`sd_lba` / `sd_rd` / `sd_wr` / `sd_ack` / `sd_buff_*`) used by core-level backup-RAM save/load logic. It answers one 512-byte sector request at a time and streams bytes between the requester's sector buffer and a local byte-wide image memory. This lets save/load paths run without the HPS, both on hardware and in self-contained benches. It also issues the mount notification (`img_mounted`, `img_size`, `img_readonly`) that the requester uses to enable backup handling.

---
 rtl/sd_sector_responder_if.sv | 29 ++
 rtl/sd_sector_responder.sv | 142 ++++++++++++++
 tb/tb_sd_sector_responder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_responder_if.sv
// Sector-buffer bus between a backup-RAM requester and its responder.
//   sd_lba        : sector number requested
//   sd_rd / sd_wr : level requests (read image->buffer / write buffer->image)
//   sd_ack        : high for the whole transfer
//   sd_buff_addr  : byte index within the sector
//   sd_buff_dout  : read data towards the requester buffer
//   sd_buff_wr    : strobe writing sd_buff_dout at sd_buff_addr
//   sd_buff_din   : requester buffer data, registered one cycle after sd_buff_addr
// master = requester side, slave = responder side.
interface sd_sector_responder_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/sd_sector_responder.sv
// Sector responder: services one 512-byte sector request at a time, moving
// bytes between the requester's sector buffer and a byte-wide image memory,
// and issues the image mount notification.
//
// Ports:
//   clk_sys, reset      : clock, asynchronous active-high reset
//   sd                  : sector-buffer bus (slave side)
//   mem_addr/rd/q/we/d  : image memory, {lba, byte index}; mem_q valid 1 cycle after mem_rd
//   mount/present/readonly : mount request and image attributes sampled with it
//   img_mounted/img_size/img_readonly : mount notification and latched attributes
//   busy                : responder not idle
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for sd_rd/sd_wr; services a pending mount when quiet
// RD_XFER | cnt 0..511 issues memory reads, cnt 512 drains the last byte
// WR_XFER | cnt 0..511 presents buffer addresses, cnt 512 drains last write
// GAP     | ack low for two cycles (cnt counts 1 down to 0)
module sd_sector_responder #(
    parameter int LBA_W = 6
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    sd_sector_responder_if.slave  sd,
    output logic [LBA_W+8:0]      mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_q,
    output logic                  mem_we,
    output logic [7:0]            mem_d,
    input  logic                  mount,
    input  logic                  present,
    input  logic                  readonly,
    output logic                  img_mounted,
    output logic [63:0]           img_size,
    output logic                  img_readonly,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, RD_XFER, WR_XFER, GAP} state_t;

    state_t           state, state_nxt;
    logic [9:0]       cnt, cnt_nxt;
    logic [LBA_W-1:0] lba_q;
    logic             lba_ok_q;
    logic [8:0]       addr_q;
    logic             rd_pipe_q, wr_pipe_q;
    logic             mount_pend_q, present_q, ro_pend_q;
    logic             accept, mount_svc, rd_issue, wr_issue;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        mount_svc = 1'b0;
        case (state)
            IDLE: begin
                if (sd.sd_rd) begin
                    accept    = 1'b1;
                    state_nxt = RD_XFER;
                    cnt_nxt   = 10'd0;
                end else if (sd.sd_wr) begin
                    accept    = 1'b1;
                    state_nxt = WR_XFER;
                    cnt_nxt   = 10'd0;
                end else if (mount_pend_q) begin
                    mount_svc = 1'b1;
                end
            end
            RD_XFER, WR_XFER: begin
                if (cnt == 10'd512) begin
                    state_nxt = GAP;
                    cnt_nxt   = 10'd1;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
            GAP: begin
                if (cnt == 10'd0) state_nxt = IDLE;
                else              cnt_nxt   = cnt - 10'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cnt[9] set only on the drain cycle (cnt == 512)
    assign rd_issue = (state == RD_XFER) && !cnt[9];
    assign wr_issue = (state == WR_XFER) && !cnt[9];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lba_q        <= '0;
            lba_ok_q     <= 1'b0;
            addr_q       <= '0;
            rd_pipe_q    <= 1'b0;
            wr_pipe_q    <= 1'b0;
            mount_pend_q <= 1'b0;
            present_q    <= 1'b0;
            ro_pend_q    <= 1'b0;
            img_mounted  <= 1'b0;
            img_size     <= '0;
            img_readonly <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_pipe_q <= rd_issue;
            wr_pipe_q <= wr_issue;
            if (accept) begin
                lba_q    <= sd.sd_lba[LBA_W-1:0];
                lba_ok_q <= (sd.sd_lba >> LBA_W) == 32'd0;
            end
            // addr_q trails cnt by one cycle: buffer index for reads,
            // memory index for writes, and holds 511 afterwards
            if (rd_issue || wr_issue) addr_q <= cnt[8:0];
            img_mounted <= mount_svc;
            if (mount_svc) begin
                img_size     <= present_q ? (64'd512 << LBA_W) : 64'd0;
                img_readonly <= ro_pend_q;
                mount_pend_q <= 1'b0;
            end
            // a mount arriving while one is being serviced stays pending
            if (mount) begin
                mount_pend_q <= 1'b1;
                present_q    <= present;
                ro_pend_q    <= readonly;
            end
        end
    end

    assign sd.sd_ack       = (state == RD_XFER) || (state == WR_XFER);
    assign busy            = (state != IDLE);
    assign sd.sd_buff_wr   = rd_pipe_q;
    assign sd.sd_buff_addr = wr_issue ? cnt[8:0] : addr_q;
    assign sd.sd_buff_dout = rd_pipe_q ? (lba_ok_q ? mem_q : 8'hFF) : 8'h00;
    assign mem_rd          = rd_issue && lba_ok_q;
    assign mem_we          = wr_pipe_q && lba_ok_q && !img_readonly;
    assign mem_d           = wr_pipe_q ? sd.sd_buff_din : 8'h00;
    assign mem_addr        = rd_issue  ? {lba_q, cnt[8:0]} :
                             wr_pipe_q ? {lba_q, addr_q}   : '0;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Bench for sd_sector_responder: image memory and requester buffer models,
// directed transfers with random data/lba, checked against a byte-level
// image model and the cycle timing of a request sampled at cycle T.
module tb_sd_sector_responder;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    sd_sector_responder_if sd_if ();

    logic [14:0] mem_addr;
    logic        mem_rd, mem_we;
    logic [7:0]  mem_q, mem_d;
    logic        mount, present, readonly;
    logic        img_mounted, img_readonly, busy;
    logic [63:0] img_size;

    sd_sector_responder #(.LBA_W(6)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sd           (sd_if),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_q        (mem_q),
        .mem_we       (mem_we),
        .mem_d        (mem_d),
        .mount        (mount),
        .present      (present),
        .readonly     (readonly),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .busy         (busy)
    );

    logic [7:0] img     [32768];
    logic [7:0] ref_img [32768];
    logic [7:0] wbuf    [512];
    logic [7:0] rbuf    [512];
    int errors = 0;
    int checks = 0;
    bit ref_ro = 1'b0;

    // image memory: preloaded with addr ^ 0x5A, one-cycle read latency
    initial begin
        mem_q = 8'h00;
        for (int a = 0; a < 32768; a++) img[a] = 8'(a) ^ 8'h5A;
        forever begin
            @(posedge clk_sys);
            if (mem_we) img[mem_addr] <= mem_d;
            if (mem_rd) mem_q <= img[mem_addr];
        end
    end

    // requester buffer: registered read port, write port from the strobe
    initial begin
        sd_if.sd_buff_din = 8'h00;
        forever begin
            @(posedge clk_sys);
            sd_if.sd_buff_din <= wbuf[sd_if.sd_buff_addr];
            if (sd_if.sd_buff_wr) rbuf[sd_if.sd_buff_addr] <= sd_if.sd_buff_dout;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{sd_if.sd_ack, sd_if.sd_buff_addr, sd_if.sd_buff_dout, sd_if.sd_buff_wr,
                 mem_addr, mem_rd, mem_we, mem_d, img_mounted, img_size, img_readonly, busy};
    endfunction

    function automatic int img_diffs();
        int n = 0;
        for (int a = 0; a < 32768; a++) if (img[a] !== ref_img[a]) n++;
        return n;
    endfunction

    task automatic do_mount(input bit pres, input bit ro);
        present  = pres;
        readonly = ro;
        mount    = 1'b1;
        @(posedge clk_sys); #1;
        mount = 1'b0;
        chk("mount_not_yet", img_mounted, 0);
        @(posedge clk_sys); #1;
        chk("mount_pulse", img_mounted, 1);
        chk("mount_size", img_size, pres ? 64'd32768 : 64'd0);
        chk("mount_ro", img_readonly, ro);
        ref_ro = ro;
        @(posedge clk_sys); #1;
        chk("mount_pulse_end", img_mounted, 0);
    endtask

    // Request raised in the current cycle T; observes T+1..T+516.
    task automatic xfer(input bit is_rd, input logic [31:0] lba,
                        input int mount_at, input int abort_at);
        int   bad = 0;
        int   first_bad = 0;
        int   ack_n = 0;
        bit   aborted = 1'b0;
        bit   in_rng, we_ok, ok;
        int   base;
        logic e_ack, e_busy, e_mrd, e_bwr, e_we;
        logic [7:0] e_byte;
        logic [7:0] wsnap [512];
        string nm;
        nm     = is_rd ? "rd" : "wr";
        in_rng = (lba < 32'd64);
        we_ok  = !is_rd && in_rng && !ref_ro;
        base   = int'(lba[5:0]) * 512;
        for (int i = 0; i < 512; i++) wsnap[i] = wbuf[i];
        sd_if.sd_lba = lba;
        if (is_rd) sd_if.sd_rd = 1'b1;
        else       sd_if.sd_wr = 1'b1;
        for (int k = 1; k <= 516; k++) begin
            @(posedge clk_sys); #1;
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                chk("reset_clears_outputs", any_out(), 0);
                chk("reset_mem_we", mem_we, 0);
                aborted = 1'b1;
                break;
            end
            e_ack  = (k <= 513);
            e_busy = (k <= 515);
            e_mrd  = is_rd && in_rng && (k <= 512);
            e_bwr  = is_rd && (k >= 2) && (k <= 513);
            e_we   = we_ok && (k >= 2) && (k <= 513);
            ok = (sd_if.sd_ack === e_ack) && (busy === e_busy) && (mem_rd === e_mrd) &&
                 (sd_if.sd_buff_wr === e_bwr) && (mem_we === e_we) && (img_mounted === 1'b0);
            if (e_bwr) begin
                e_byte = in_rng ? ref_img[base + k - 2] : 8'hFF;
                ok &= (sd_if.sd_buff_addr === 9'(k - 2)) && (sd_if.sd_buff_dout === e_byte);
            end else if (!is_rd && k <= 512) begin
                ok &= (sd_if.sd_buff_addr === 9'(k - 1));
            end else if (k >= 513) begin
                ok &= (sd_if.sd_buff_addr === 9'd511);
            end
            if (e_we) ok &= (mem_addr === 15'(base + k - 2)) && (mem_d === wsnap[k - 2]);
            if (!ok) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
            if (sd_if.sd_ack === 1'b1) ack_n++;
            if (k == 1) begin
                if (is_rd) sd_if.sd_rd = 1'b0;
                else       sd_if.sd_wr = 1'b0;
            end
            mount = (k == mount_at);
        end
        if (aborted) begin
            if (we_ok) for (int i = 0; i < abort_at - 2; i++) ref_img[base + i] = wsnap[i];
        end else begin
            chk($sformatf("%s_ack_cycles lba=%0h", nm, lba), 64'(ack_n), 64'd513);
            chk($sformatf("%s_trace lba=%0h first_bad_cycle=%0d", nm, lba, first_bad),
                64'(bad), 64'd0);
            if (we_ok) for (int i = 0; i < 512; i++) ref_img[base + i] = wsnap[i];
            if (is_rd) begin
                int nb = 0;
                for (int i = 0; i < 512; i++)
                    if (rbuf[i] !== (in_rng ? ref_img[base + i] : 8'hFF)) nb++;
                chk($sformatf("rd_buffer lba=%0h", lba), 64'(nb), 64'd0);
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
    endtask

    initial begin
        logic [31:0] l;
        sd_if.sd_lba = '0;
        sd_if.sd_rd  = 1'b0;
        sd_if.sd_wr  = 1'b0;
        mount    = 1'b0;
        present  = 1'b0;
        readonly = 1'b0;
        for (int a = 0; a < 32768; a++) ref_img[a] = 8'(a) ^ 8'h5A;
        for (int i = 0; i < 512; i++) wbuf[i] = 8'h00;

        repeat (3) @(posedge clk_sys);
        #1;
        chk("outputs_in_reset", any_out(), 0);
        reset = 1'b0;
        @(posedge clk_sys); #1;
        chk("outputs_after_reset", any_out(), 0);

        do_mount(1'b1, 1'b0);

        xfer(1'b1, 32'd3, 0, 0);

        for (int i = 0; i < 512; i++) wbuf[i] = 8'(i);
        xfer(1'b0, 32'd63, 0, 0);
        chk("img_after_wr63", 64'(img_diffs()), 0);

        // out-of-range sectors
        xfer(1'b1, 32'd64, 0, 0);
        fill_random();
        xfer(1'b0, 32'd64, 0, 0);
        l = 32'd64 + 32'($urandom_range(0, 32'h7FFF0000));
        xfer(1'b1, l, 0, 0);
        xfer(1'b0, l, 0, 0);
        chk("img_after_oor", 64'(img_diffs()), 0);

        // write-protected image
        do_mount(1'b1, 1'b1);
        fill_random();
        xfer(1'b0, 32'($urandom_range(0, 63)), 0, 0);
        chk("img_after_ro_write", 64'(img_diffs()), 0);
        do_mount(1'b1, 1'b0);

        // read and write raised together: read first, then write at T+516
        l = 32'($urandom_range(0, 63));
        fill_random();
        sd_if.sd_wr = 1'b1;
        xfer(1'b1, l, 0, 0);
        xfer(1'b0, l, 0, 0);
        xfer(1'b1, l, 0, 0);

        // mount during a transfer is deferred until IDLE
        xfer(1'b1, 32'($urandom_range(0, 63)), 100, 0);
        @(posedge clk_sys); #1;
        chk("deferred_mount_pulse", img_mounted, 1);
        chk("deferred_mount_size", img_size, 64'd32768);
        @(posedge clk_sys); #1;
        chk("deferred_mount_end", img_mounted, 0);

        // save / load loops
        for (int s = 0; s < 64; s++) begin
            fill_random();
            xfer(1'b0, 32'(s), 0, 0);
        end
        chk("img_after_save", 64'(img_diffs()), 0);
        for (int s = 0; s < 64; s++) xfer(1'b1, 32'(s), 0, 0);

        do_mount(1'b0, 1'b0);

        // reset mid-write at T+200
        l = 32'($urandom_range(0, 63));
        fill_random();
        xfer(1'b0, l, 0, 200);
        @(posedge clk_sys); #1;
        chk("outputs_held_in_reset", any_out(), 0);
        reset  = 1'b0;
        ref_ro = 1'b0;
        @(posedge clk_sys); #1;
        chk("img_after_abort", 64'(img_diffs()), 0);
        xfer(1'b1, l, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
